// File: rtl/xmem_responder.sv
// Purpose : memory-mapped byte SRAM window for an AVR-style core with a fixed number of wait states.
// Latency : a hit stalls the core for WAIT_STATES cycles; access_stb pulses the cycle after completion.
// Backpr. : sram_wait holds the core; dropping the request mid-access aborts it with no side effects.
//
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   sram_a/_d_out      byte address and write data from the core
//   sram_cs/_oe/_we    request and read/write strobes
//   sram_d_in          registered read data
//   sram_wait          combinational stall to the core
//   access_stb         one-cycle pulse per completed hit access
//   proto_err          sticky flag: read and write strobes both set at access start
module xmem_responder #(
   parameter int          ADDR_BITS   = 10,
   parameter logic [15:0] BASE_ADDR   = 16'h1000,
   parameter int          WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [15:0] sram_a,
   input  logic [7:0]  sram_d_out,
   output logic [7:0]  sram_d_in,
   input  logic        sram_cs,
   input  logic        sram_oe,
   input  logic        sram_we,
   output logic        sram_wait,
   output logic        access_stb,
   output logic        proto_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t               r_state;
   logic [3:0]           r_cnt;
   logic [ADDR_BITS-1:0] r_off;
   logic                 r_wr;
   logic [7:0]           r_wdat;
   logic [7:0]           r_rdat;
   logic                 r_stb;
   logic                 r_err;
   logic [7:0]           r_mem [0:(1<<ADDR_BITS)-1];

   logic w_req;
   logic w_hit;
   logic w_done;

   assign w_req  = sram_cs && (sram_oe || sram_we);
   assign w_hit  = w_req && (sram_a[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
   // Completion: last wait state elapsed and the core is still requesting.
   assign w_done = (r_state == S_WAIT) && w_req && (r_cnt == 4'd0);

   // Stall while an access is in progress; released in the completion cycle,
   // on abort, on miss, and whenever reset is asserted.
   always_comb begin
      sram_wait = 1'b0;
      if (nrst) begin
         if (r_state == S_IDLE)
            sram_wait = w_hit;
         else
            sram_wait = w_req && (r_cnt != 4'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_off   <= '0;
         r_wr    <= 1'b0;
         r_wdat  <= 8'h00;
         r_rdat  <= 8'h00;
         r_stb   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_stb <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  r_off   <= sram_a[ADDR_BITS-1:0];
                  r_wr    <= sram_we;
                  r_wdat  <= sram_d_out;
                  r_cnt   <= 4'(WAIT_STATES - 1);
                  r_state <= S_WAIT;
                  // Reads sample memory up front; both strobes together is a write.
                  if (!sram_we)
                     r_rdat <= r_mem[sram_a[ADDR_BITS-1:0]];
                  if (sram_oe && sram_we)
                     r_err <= 1'b1;
               end
            end
            S_WAIT: begin
               if (!w_req)
                  r_state <= S_IDLE;
               else if (r_cnt != 4'd0)
                  r_cnt <= r_cnt - 4'd1;
               else begin
                  r_stb   <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Memory has no reset; writes commit only on the edge ending a completed access.
   always_ff @(posedge clk) begin
      if (nrst && w_done && r_wr)
         r_mem[r_off] <= r_wdat;
   end

   assign sram_d_in  = r_rdat;
   assign access_stb = r_stb;
   assign proto_err  = r_err;

endmodule

// File: doc/xmem_responder.md
XMEM_RESPONDER -- requirements
Module: xmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10: on-chip byte memory depth is 2^ADDR_BITS; legal range 4..15.
REQ-002 SHALL have parameter BASE_ADDR, default 16'h1000: window base; only bits [15:ADDR_BITS] are significant.
REQ-003 SHALL have parameter WAIT_STATES, default 2: stall cycles per hit access; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 nrst  input  1  reset, synchronous and active-low.
REQ-006 sram_a  input  16  byte address from the AVR core.
REQ-007 sram_d_out  input  8  write data from the AVR core.
REQ-008 sram_d_in  output  8  read data to the AVR core; registered.
REQ-009 sram_cs  input  1  access request.
REQ-010 sram_oe  input  1  read strobe; qualified by sram_cs.
REQ-011 sram_we  input  1  write strobe; qualified by sram_cs.
REQ-012 sram_wait  output  1  stall to the AVR core; combinational from state, counter and request inputs.
REQ-013 access_stb  output  1  one-cycle pulse on each completed hit access; registered.
REQ-014 proto_err  output  1  sticky error flag; registered.

Function
REQ-015 Request: sram_cs=1 and (sram_oe=1 or sram_we=1); hit: request and sram_a[15:ADDR_BITS]==BASE_ADDR[15:ADDR_BITS].
REQ-016 SHALL implement FSM with states IDLE and WAIT plus a 4-bit counter cnt.
REQ-017 In IDLE, hit (cycle T0): sram_wait=1, capture address offset, direction and write data, load cnt=WAIT_STATES-1, go to WAIT.
REQ-018 In WAIT with cnt!=0 and request still present: sram_wait=1, cnt decrements.
REQ-019 In WAIT with cnt==0 and request still present (completion cycle T(WAIT_STATES)): sram_wait=0, go to IDLE, access_stb=1 in the following cycle.
REQ-020 Each hit access SHALL therefore stall exactly WAIT_STATES cycles and occupy WAIT_STATES+1 cycles.
REQ-021 Write SHALL commit captured data to memory[captured offset] at the clock edge ending the completion cycle; never earlier.
REQ-022 Read SHALL perform the memory read at the T0 edge into the read register driving sram_d_in; value is held until the next hit read completes its read.
REQ-023 Address, data and direction changes during WAIT SHALL be ignored; values captured at T0 are used.
REQ-024 Request dropping (sram_cs=0, or both strobes 0) in WAIT SHALL abort the access: go to IDLE, no write, no access_stb, sram_wait=0 in that cycle.
REQ-025 A request in the cycle after completion SHALL be treated as a new access starting at T0; back-to-back accesses SHALL NOT merge.
REQ-026 Miss (request outside window): sram_wait=0, no memory write, sram_d_in unchanged, no access_stb, state stays IDLE.
REQ-027 sram_oe=1 and sram_we=1 together at T0: SHALL be performed as a write and SHALL set proto_err=1.
REQ-028 proto_err SHALL remain 1 until reset.
REQ-029 No request: sram_wait=0.
REQ-030 Memory contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-031 While nrst=0 at a clock edge: state=IDLE, cnt=0, sram_d_in=8'h00, access_stb=0, proto_err=0.
REQ-032 sram_wait SHALL be 0 in every cycle in which state is IDLE and nrst=0.
REQ-033 Reset asserted mid-access SHALL abort it: pending write SHALL NOT commit, no access_stb.
REQ-034 First request after nrst returns high SHALL start a fresh access at T0.

Verification
REQ-035 Default parameters; write 8'hA5 to 16'h1003, then read 16'h1003 -> sram_wait high exactly 2 cycles each; sram_d_in=8'hA5 at read completion; one access_stb per access.
REQ-036 Read 16'h2000 (miss) -> sram_wait never high; sram_d_in unchanged; no access_stb.
REQ-037 Write 8'h3C to 16'h1010 with sram_a and sram_d_out changed to 16'h1011 / 8'hFF after T0 -> memory[16'h10] is 8'h3C; memory[16'h11] is unchanged.
REQ-038 Write to 16'h1020 with sram_cs dropped in first WAIT cycle -> no write, no access_stb; next read of 16'h1020 returns the prior value.
REQ-039 Write to 16'h1030 with nrst pulsed low during WAIT -> no write; outputs at reset values; proto_err=0.
REQ-040 sram_oe and sram_we both high, data 8'h77, address 16'h1040 -> write performed; proto_err=1 and stays 1 until nrst=0.
